nand_sequencer: RTL
===================

NAND_SEQUENCER -- requirements
Module: nand_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1, request present.
REQ-005 SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-006 SHALL have port req_op, input, 3, opcode: 000 NAND, 001 NOT (in0 only), 010 AND, 011 OR, 100 NOR, 101 XOR, 110 XNOR, 111 illegal.
REQ-007 SHALL have ports in0, in1, input, 1 each, operands.
REQ-008 SHALL have port rsp_valid, output, 1, result present.
REQ-009 SHALL have port rsp_ready, input, 1, result consumed when high with rsp_valid.
REQ-010 SHALL have port out, output, 1, result bit.
REQ-011 SHALL have port err, output, 1, illegal or disabled opcode flag, qualified by rsp_valid.
REQ-012 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-013 SHALL have port ops_done, output, CNT_W, count of completed response handshakes.

Function
REQ-014 SHALL contain exactly one NAND_GATE instance; every logic result SHALL come from sequential evaluations of that instance, with at most one evaluation per cycle.
REQ-015 SHALL implement states IDLE, EXEC and DONE; req_ready is high only in IDLE.
REQ-016 IDLE to EXEC on req_valid with a legal opcode; operands and opcode latched on that edge; step counter cleared.
REQ-017 SHALL use these EXEC step sequences (t = internal temps): NAND: r=N(a,b), 1 step; NOT: r=N(a,a), 1; AND: t0=N(a,b), r=N(t0,t0), 2; OR: t0=N(a,a), t1=N(b,b), r=N(t0,t1), 3; NOR: OR steps then r=N(r,r), 4; XOR: t0=N(a,b), t1=N(a,t0), t2=N(b,t0), r=N(t1,t2), 4; XNOR: XOR steps then r=N(r,r), 5.
REQ-018 EXEC to DONE on the edge that completes the final step; rsp_valid rises the cycle after the final step, so latency from accept edge to rsp_valid equals step count plus 1 cycle.
REQ-019 In DONE, out, err and rsp_valid SHALL hold stable until rsp_ready; on handshake go to IDLE; req_ready high the following cycle.
REQ-020 Illegal opcode accepted in IDLE SHALL go directly to DONE with err=1, out=0; rsp_valid high the next cycle; no NAND steps executed.
REQ-021 Inputs changing during EXEC or DONE SHALL not affect the in-flight result.
REQ-022 ops_done SHALL increment by 1 on every response handshake, including err responses, and wrap from all-ones to 0.
REQ-023 rsp_ready asserted while rsp_valid is low SHALL be ignored.

Reset
REQ-024 When rst is high at a clock edge: state IDLE, req_ready=1 on the next cycle, rsp_valid=0, out=0, err=0, busy=0, ops_done=0, and all temps and the step counter are 0.
REQ-025 rst SHALL take priority over every other event; an in-flight operation is discarded with no response and no count increment.

Configuration
REQ-026 With macro NAND_SEQ_XNOR_EN defined, opcode 110 SHALL execute the 5-step XNOR sequence.
REQ-027 Without NAND_SEQ_XNOR_EN, opcode 110 SHALL be treated exactly as illegal per REQ-020 (err=1, out=0).

Verification
REQ-028 Reset, then XOR with in0=1, in1=0 accepted at edge E -> rsp_valid at E+5, out=1, err=0, busy high during E+1..E+5, ops_done=1 after handshake.
REQ-029 All 7 legal opcodes with all 4 operand pairs, rsp_ready held high -> out matches the truth table; rsp_valid appears step count plus 1 cycles after acceptance.
REQ-030 AND with in0=1, in1=1, rsp_ready low for 10 cycles, in0/in1 toggling meanwhile -> out stays 1, rsp_valid stays high, req_ready stays 0.
REQ-031 Opcode 111 -> rsp_valid one cycle after accept, err=1, out=0; opcode 110 gives err=1 without the macro and a correct XNOR with it.
REQ-032 rst asserted mid-EXEC of NOR -> next cycle: IDLE, rsp_valid=0, ops_done unchanged from 0.
REQ-033 CNT_W=2, 5 back-to-back NOT requests -> ops_done sequence 1,2,3,0,1.

Source files
------------

// File: rtl/nand_sequencer.sv
// Evaluates 1-bit logic ops as a serial sequence of NAND steps on one shared gate; req/rsp valid-ready.
// XNOR (opcode 110) is only executed when NAND_SEQ_XNOR_EN is defined, otherwise it returns err.
module nand_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module nand_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             in0,
  input  logic             in1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             out,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

`ifdef NAND_SEQ_XNOR_EN
  localparam logic XNOR_EN = 1'b1;
`else
  localparam logic XNOR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic             a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d, step_q, step_d;
  logic             t0_q, t0_d, t1_q, t1_d, t2_q, t2_d, r_q, r_d;
  logic             out_q, out_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       nx, ny, nz;
  logic [1:0] dst;  // 0:t0 1:t1 2:t2 3:r
  logic       last;
  logic       legal;

  nand_gate u_nand_gate (.a(nx), .b(ny), .y(nz));

  assign legal = (req_op != 3'b111) && ((req_op != 3'b110) || XNOR_EN);

  // Step table: gate operands, destination and final-step flag per opcode/step.
  always_comb begin
    nx   = a_q;
    ny   = b_q;
    dst  = 2'd3;
    last = 1'b1;
    case (op_q)
      3'b001: ny = a_q;
      3'b010: begin
        last = (step_q == 3'd1);
        if (step_q == 3'd0) dst = 2'd0;
        else begin nx = t0_q; ny = t0_q; end
      end
      3'b011, 3'b100: begin
        last = (step_q == ((op_q == 3'b100) ? 3'd3 : 3'd2));
        case (step_q)
          3'd0:    begin ny = a_q; dst = 2'd0; end
          3'd1:    begin nx = b_q; dst = 2'd1; end
          3'd2:    begin nx = t0_q; ny = t1_q; end
          default: begin nx = r_q; ny = r_q; end
        endcase
      end
      3'b101, 3'b110: begin
        last = (step_q == ((op_q == 3'b110) ? 3'd4 : 3'd3));
        case (step_q)
          3'd0:    dst = 2'd0;
          3'd1:    begin ny = t0_q; dst = 2'd1; end
          3'd2:    begin nx = b_q; ny = t0_q; dst = 2'd2; end
          3'd3:    begin nx = t1_q; ny = t2_q; end
          default: begin nx = r_q; ny = r_q; end
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    step_d  = step_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    r_d     = r_q;
    out_d   = out_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d    = in0;
          b_d    = in1;
          op_d   = req_op;
          step_d = 3'd0;
          if (legal) begin
            state_d = EXEC;
          end else begin
            state_d = DONE;
            out_d   = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      EXEC: begin
        case (dst)
          2'd0:    t0_d = nz;
          2'd1:    t1_d = nz;
          2'd2:    t2_d = nz;
          default: r_d  = nz;
        endcase
        step_d = step_q + 3'd1;
        if (last) begin
          state_d = DONE;
          out_d   = nz;
          err_d   = 1'b0;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
          cnt_d   = cnt_q + 1'b1;
          out_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      op_q    <= 3'd0;
      step_q  <= 3'd0;
      t0_q    <= 1'b0;
      t1_q    <= 1'b0;
      t2_q    <= 1'b0;
      r_q     <= 1'b0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      step_q  <= step_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      r_q     <= r_d;
      out_q   <= out_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out       = out_q;
  assign err       = err_q;
  assign ops_done  = cnt_q;

endmodule
